sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
Shares one single-port sprite frame ROM among several requesters: player tank, enemy tanks, and the bullet/explosion renderers. The ROM has 1-cycle registered read latency, a 19-bit address and 24-bit RGB output. The arbiter sits between the per-object draw logic and the ROM, grants one read per cycle, and routes returned pixels back to the originating requester. Grants are round-robin with optional row-burst locking.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 19, ROM read address width
DATA_W, 24, ROM pixel width (RGB888)
MAX_BURST, 32, max consecutive locked grants to one requester before forced release (1..255)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
req  in  N_REQ  per-requester read request, held until granted
req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_lock  in  N_REQ  requester wants to keep the grant next cycle (row burst)
gnt  out  N_REQ  one-hot grant; request accepted when req[i]&gnt[i]
rom_addr  out  ADDR_W  registered address to ROM read_address
rom_data  in  DATA_W  ROM data_Out, valid 1 cycle after rom_addr
rvalid  out  N_REQ  one-hot: rdata belongs to requester i
rdata  out  DATA_W  returned pixel
busy  out  1  high while any read is in flight or a lock is held

Behaviour:
- Reset (Reset_n=0 at posedge): gnt=0, rvalid=0, rdata=0, rom_addr=0, busy=0; RR pointer=0; burst counter=0; in-flight pipeline flushed. Reads in flight are discarded and no rvalid is issued for them.
- gnt is combinational from req, FSM state and the RR pointer. At most one bit is set. gnt is 0 when req=0.
- Pipeline:
  - Cycle T: accept (req[i]&gnt[i]).
  - T+1: rom_addr<=req_addr[i] and tag<=i.
  - T+2: rom_data valid; rdata<=rom_data and rvalid<=onehot(tag), visible at T+3 register output.
  - Fixed accept-to-rvalid latency is 3 cycles. Throughput is 1 read/cycle. No backpressure on return: the requester must sink rvalid.
- rom_addr holds its last value when there is no accept. rvalid deasserts the cycle after the last return.
- FSM states: ARB, LOCKED.
  - ARB: grant the first asserted req scanning from the RR pointer upward (mod N_REQ). On accept, the pointer becomes winner+1 mod N_REQ. If req_lock[winner]=1, go to LOCKED with owner=winner and burst_cnt=1.
  - LOCKED: gnt=onehot(owner) only. Each accept increments burst_cnt.
  - Exit to ARB when any of: req[owner]=0; req_lock[owner]=0 on an accept; burst_cnt reaches MAX_BURST. The final accept is still honoured, and the next cycle arbitrates from pointer=owner+1.
- Simultaneous events:
  - Lock release and a new req elsewhere in the same cycle: the new req is arbitrated the following cycle.
  - req_lock without req is ignored.
- Wrap-around: the pointer wraps N_REQ-1 to 0. burst_cnt is 8 bits and saturates; it never wraps.
- MAX_BURST=1 makes lock ineffective (pure round-robin).
- busy = (state==LOCKED) | any pipeline stage valid.

Optional Feature:
SPRITE_ARB_PLAYER_PRIO_EN
- Defined: requester 0 (player tank) has strict priority in ARB. When req[0]=1 it wins regardless of the pointer, and the pointer is not updated on its win. LOCKED owners are still preempted only at burst exit.
- Undefined: requester 0 is treated like all others under round-robin.

Decomposition:
- Package sprite_arb_pkg holds:
  - arb_state_t enum {ARB, LOCKED}
  - localparam ROM_LAT=1 and derived RET_LAT=3
  - function onehot(idx, N) and a rotate-priority-pick function
- One sub-module, rr_pick: a combinational rotate-and-find-first, taking req and pointer and returning a one-hot winner plus its index.
- The pipeline and FSM stay in the top module.

Test Plan:
- Reset mid-burst: lock req 2 for 5 reads, drop Reset_n on read 3 → no rvalid after reset, gnt=0, pointer=0, busy=0 the next cycle.
- Single requester: req[1]=1, addr 0x00010 then 0x00011 back-to-back → gnt[1] on both cycles; rom_addr shows 0x00010 then 0x00011; rvalid[1] with matching ROM pixels exactly 3 cycles after each accept.
- Round-robin fairness: req=4'b1111 for 8 cycles, no lock → grant order 0,1,2,3,0,1,2,3.
- Burst lock cap: MAX_BURST=4, req[3] and req_lock[3] held high, req[0]=1 → four grants to 3, then grant 0, then 3 again.
- Lock released by req drop: owner 2 deasserts req after 2 accepts while req[1]=1 → state returns to ARB; next grant goes to 3 if requesting, else 0, else 1, scanning from pointer 3.
- With SPRITE_ARB_PLAYER_PRIO_EN defined: req=4'b1111 → requester 0 is granted every cycle in ARB and the other requesters starve. Without it, same stimulus gives round-robin 0,1,2,3.

Source files
------------

// File: rtl/sprite_rom_arbiter_pkg.sv
// sprite_arb_pkg: shared types and helpers for the sprite ROM arbiter
package sprite_arb_pkg;
  typedef enum logic {ARB, LOCKED} arb_state_t;
  localparam int ROM_LAT = 1;
  localparam int RET_LAT = ROM_LAT + 2;
  localparam int PTR_W = 3;
  function automatic logic [7:0] onehot(input logic [PTR_W-1:0] idx, input int n);
    onehot = '0;
    if (int'(idx) < n) onehot[idx] = 1'b1;
  endfunction
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int n);
    return int'(p) == n - 1 ? '0 : p + 1'b1;
  endfunction
  // Descending scan so the requester closest to the pointer is written last and wins.
  function automatic logic [PTR_W:0] rr_first(input logic [7:0] r, input logic [PTR_W-1:0] p, input int n);
    logic [PTR_W:0] res;
    logic [PTR_W-1:0] j;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        j = PTR_W'((int'(p) + k) % n);
        if (r[j]) res = {1'b1, j};
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: requester-side request/return bus plus ROM read port
interface sprite_rom_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
);
  logic [N_REQ-1:0] req, req_lock, gnt, rvalid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data, rdata;
  logic busy;
  modport master(output req, req_addr, req_lock, rom_data, input gnt, rom_addr, rvalid, rdata, busy);
  modport slave(input req, req_addr, req_lock, rom_data, output gnt, rom_addr, rvalid, rdata, busy);
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rr_pick: combinational rotate-and-find-first starting at the round-robin pointer
module rr_pick import sprite_arb_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [PTR_W-1:0] idx
);
  logic [PTR_W:0] pick;
  always_comb begin
    pick = rr_first(8'(req), ptr, N_REQ);
    idx = pick[PTR_W-1:0];
    win = pick[PTR_W] ? N_REQ'(onehot(idx, N_REQ)) : '0;
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one sprite ROM with row-burst locking
// SPRITE_ARB_PLAYER_PRIO_EN gives requester 0 strict priority while arbitrating.
module sprite_rom_arbiter import sprite_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24,
  parameter int MAX_BURST = 32
) (
  input logic Clk,
  input logic Reset_n,
  sprite_rom_arbiter_if.slave bus
);
  arb_state_t state, state_nx;
  logic [PTR_W-1:0] ptr, ptr_nx, owner, owner_nx, pick_idx, arb_idx, win_idx, tag1, tag2;
  logic [7:0] burst_cnt, burst_nx, burst_inc;
  logic [N_REQ-1:0] pick_win, arb_gnt, gnt, owner_oh;
  logic [ADDR_W-1:0] addr_sel;
  logic prio_win, own_req, own_lock, win_lock, accept, v1, v2;
  rr_pick #(.N_REQ(N_REQ)) u_pick (.req(bus.req), .ptr(ptr), .win(pick_win), .idx(pick_idx));
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
  assign prio_win = bus.req[0];
`else
  assign prio_win = 1'b0;
`endif
  assign arb_gnt = prio_win ? N_REQ'(1) : pick_win;
  assign arb_idx = prio_win ? '0 : pick_idx;
  assign owner_oh = N_REQ'(onehot(owner, N_REQ));
  assign own_req = |(bus.req & owner_oh);
  assign own_lock = |(bus.req_lock & owner_oh);
  assign win_lock = |(bus.req_lock & arb_gnt);
  assign bus.gnt = gnt;
  assign bus.busy = state == LOCKED || v1 || v2 || |bus.rvalid;
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    owner_nx = owner;
    burst_nx = burst_cnt;
    gnt = state == LOCKED ? (own_req ? owner_oh : '0) : arb_gnt;
    win_idx = state == LOCKED ? owner : arb_idx;
    accept = |(bus.req & gnt);
    burst_inc = burst_cnt == 8'hFF ? burst_cnt : burst_cnt + 8'd1;
    if (state == ARB) begin
      if (accept) begin
        ptr_nx = prio_win ? ptr : ptr_inc(arb_idx, N_REQ);
        if (win_lock && MAX_BURST > 1) begin
          state_nx = LOCKED;
          owner_nx = arb_idx;
          burst_nx = 8'd1;
        end
      end
    end else if (!own_req || !own_lock || int'(burst_inc) >= MAX_BURST) begin
      state_nx = ARB;
      ptr_nx = ptr_inc(owner, N_REQ);
      burst_nx = '0;
    end else burst_nx = burst_inc;
  end
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < N_REQ; i++) addr_sel |= gnt[i] ? bus.req_addr[i*ADDR_W +: ADDR_W] : '0;
  end
  // Tag travels alongside the ROM's registered read so the pixel returns to its owner.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= ARB;
      ptr <= '0;
      owner <= '0;
      burst_cnt <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
      bus.rom_addr <= '0;
      bus.rvalid <= '0;
      bus.rdata <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      owner <= owner_nx;
      burst_cnt <= burst_nx;
      v1 <= accept;
      if (accept) begin
        bus.rom_addr <= addr_sel;
        tag1 <= win_idx;
      end
      v2 <= v1;
      tag2 <= tag1;
      bus.rvalid <= v2 ? N_REQ'(onehot(tag2, N_REQ)) : '0;
      if (v2) bus.rdata <= bus.rom_data;
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed stimulus with a return-path scoreboard for sprite_rom_arbiter
module tb_sprite_rom_arbiter;
  localparam int N = 4, AW = 19, DW = 24;
  typedef struct {int idx; logic [DW-1:0] data; int cyc;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  exp_t q[$];
  exp_t e;
  logic [AW-1:0] rom_exp = '0;
  sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();
  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus));
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {a, 5'h15} ^ 24'h5A5A5A;
  endfunction
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.rom_data <= rom_f(bus.rom_addr);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && cyc > q[0].cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_rvalid: got none expected requester %0d at cycle %0d", e.idx, e.cyc);
      end
      if (bus.rvalid !== '0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got %b expected none", bus.rvalid);
        end else begin
          e = q.pop_front();
          chk("rvalid", 32'(bus.rvalid), 32'(1) << e.idx);
          chk("rdata", 32'(bus.rdata), 32'(e.data));
          chk("ret_cycle", cyc, e.cyc);
        end
      end
    end
  end
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [AW-1:0] a,
                      input logic [N-1:0] eg, input string name);
    @(negedge clk);
    #1;
    chk("rom_addr", 32'(bus.rom_addr), 32'(rom_exp));
    bus.req = r;
    bus.req_lock = l;
    for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = a ^ AW'(i << 16);
    #1;
    chk(name, 32'(bus.gnt), 32'(eg));
    for (int i = 0; i < N; i++)
      if (eg[i] && r[i]) begin
        rom_exp = a ^ AW'(i << 16);
        q.push_back('{i, rom_f(rom_exp), cyc + 3});
      end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, "idle_gnt");
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    rom_exp = '0;
    @(negedge clk);
    #1;
    bus.req = '0;
    bus.req_lock = '0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req = '0;
    bus.req_lock = '0;
    bus.req_addr = '0;
    do_reset();
    // single requester, back-to-back: rom_addr 0x00010 then 0x00011
    step(4'b0010, 4'b0000, 19'h10010, 4'b0010, "single_gnt0");
    step(4'b0010, 4'b0000, 19'h10011, 4'b0010, "single_gnt1");
    idle(1);
    chk("busy_inflight", 32'(bus.busy), 1);
    idle(4);
    chk("busy_drained", 32'(bus.busy), 0);
    // lock on 2, released by dropping req while 3 appears; pointer then 3
    step(4'b0100, 4'b0100, 19'h00200, 4'b0100, "drop_lock_win");
    step(4'b0110, 4'b0100, 19'h00201, 4'b0100, "drop_locked");
    chk("busy_locked", 32'(bus.busy), 1);
    step(4'b1010, 4'b0000, 19'h00202, 4'b0000, "drop_release");
    step(4'b1010, 4'b0000, 19'h00203, 4'b1000, "drop_next3");
    step(4'b0010, 4'b0000, 19'h00204, 4'b0010, "drop_next1");
    // burst cap of 4 on requester 3 with requester 0 waiting
    step(4'b1000, 4'b1000, 19'h00300, 4'b1000, "cap_g1");
    step(4'b1001, 4'b1000, 19'h00301, 4'b1000, "cap_g2");
    step(4'b1001, 4'b1000, 19'h00302, 4'b1000, "cap_g3");
    step(4'b1001, 4'b1000, 19'h00303, 4'b1000, "cap_g4");
    step(4'b1001, 4'b1000, 19'h00304, 4'b0001, "cap_g0");
    step(4'b1000, 4'b1000, 19'h00305, 4'b1000, "cap_g3_again");
    step(4'b0000, 4'b0000, 19'h00306, 4'b0000, "cap_release");
    // req_lock on non-requesting or non-winning requesters is ignored
    step(4'b0010, 4'b1101, 19'h00400, 4'b0010, "lock_noreq");
    step(4'b0100, 4'b0000, 19'h00401, 4'b0100, "lock_noreq_next");
    idle(5);
    // reset on the third read of a locked burst
    step(4'b0100, 4'b0100, 19'h00500, 4'b0100, "rst_burst1");
    step(4'b0100, 4'b0100, 19'h00501, 4'b0100, "rst_burst2");
    do_reset();
    idle(5);
    // round-robin from pointer 0 after reset, with wrap 3 -> 0
    for (int k = 0; k < 8; k++)
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
      step(4'b1111, 4'b0000, AW'(19'h00600 + k), 4'b0001, "rr_gnt");
`else
      step(4'b1111, 4'b0000, AW'(19'h00600 + k), 4'(1 << (k % 4)), "rr_gnt");
`endif
    idle(6);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
